// File: rtl/mem_access_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_stage_pkg
// Brief   : Shared encodings and defaults for the memory-access stage
// Revision: 1.0 - initial release
// ============================================================================
package mem_access_stage_pkg;

    localparam int DATA_WIDTH_DEF     = 32;
    localparam int REG_ADDR_WIDTH_DEF = 5;
    localparam int TIMEOUT_CYCLES_DEF = 15;

    // Architectural zero register (XZR): writes to it are discarded
    localparam logic [4:0] REG_ZERO = 5'd31;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01
    } state_t;

    // An op needs the cache only when exactly one of read/write is set
    function automatic logic needs_cache(input logic rd, input logic wr);
        return rd ^ wr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_stage_req_timeout_counter.sv
`default_nettype none
// ============================================================================
// Module  : req_timeout_counter
// Brief   : Counts stalled request cycles; flags the cycle that hits the limit
// Revision: 1.0 - initial release
// ============================================================================
module req_timeout_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             enable,
    input  logic [WIDTH-1:0] limit,
    output logic             expired
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Clear has priority; otherwise count every enabled cycle
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Counter register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Expired during the cycle whose count would reach the limit
    assign expired = enable && !clear && (count_q == (limit - WIDTH'(1)));

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_stage
// Brief   : Captures ALU results, runs req/ack cache transactions for LD/STR,
//           and emits a single writeback beat per retired op
// Revision: 1.0 - initial release
// ============================================================================
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WIDTH-1:0]     alu_result,
    input  logic [DATA_WIDTH-1:0]     store_data,
    input  logic                      mem_read,
    input  logic                      mem_write,
    input  logic                      mem_to_reg,
    input  logic                      reg_write,
    input  logic [REG_ADDR_WIDTH-1:0] write_register,
    output logic                      mem_req,
    output logic                      mem_we,
    output logic [DATA_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic                      mem_ack,
    input  logic [DATA_WIDTH-1:0]     mem_rdata,
    output logic                      wb_valid,
    output logic                      wb_we,
    output logic [REG_ADDR_WIDTH-1:0] wb_register,
    output logic [DATA_WIDTH-1:0]     wb_data,
    output logic                      err_timeout,
    output logic                      err_illegal
);

    localparam int                          CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]            CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [REG_ADDR_WIDTH-1:0]   ZERO_IDX  = REG_ADDR_WIDTH'(REG_ZERO);

    state_t                       state_q, state_d;
    logic [DATA_WIDTH-1:0]        addr_q, addr_d;
    logic [DATA_WIDTH-1:0]        wdata_q, wdata_d;
    logic                         we_q, we_d;
    logic                         load_to_reg_q, load_to_reg_d;
    logic                         reg_write_q, reg_write_d;
    logic [REG_ADDR_WIDTH-1:0]    dest_q, dest_d;
    logic                         wb_valid_q, wb_valid_d;
    logic                         wb_we_q, wb_we_d;
    logic [REG_ADDR_WIDTH-1:0]    wb_reg_q, wb_reg_d;
    logic [DATA_WIDTH-1:0]        wb_data_q, wb_data_d;
    logic                         err_timeout_q, err_timeout_d;
    logic                         err_illegal_q, err_illegal_d;
    logic                         cnt_clear;
    logic                         cnt_enable;
    logic                         cnt_expired;

    assign cnt_enable = (state_q == ST_REQ) && !mem_ack;

    req_timeout_counter #(
        .WIDTH (CNT_W)
    ) u_req_timeout_counter (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .limit   (CNT_LIMIT),
        .expired (cnt_expired)
    );

    // Next-state, capture and writeback selection
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        we_d          = we_q;
        load_to_reg_d = load_to_reg_q;
        reg_write_d   = reg_write_q;
        dest_d        = dest_q;
        wb_valid_d    = 1'b0;
        wb_we_d       = 1'b0;
        wb_reg_d      = wb_reg_q;
        wb_data_d     = wb_data_q;
        err_timeout_d = err_timeout_q;
        err_illegal_d = err_illegal_q;
        cnt_clear     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    if (mem_read && mem_write) begin
                        // Conflicting op: retire without touching the cache
                        wb_valid_d    = 1'b1;
                        wb_reg_d      = write_register;
                        wb_data_d     = alu_result;
                        err_illegal_d = 1'b1;
                    end else if (needs_cache(mem_read, mem_write)) begin
                        state_d       = ST_REQ;
                        addr_d        = alu_result;
                        wdata_d       = store_data;
                        we_d          = mem_write;
                        load_to_reg_d = mem_read && mem_to_reg;
                        reg_write_d   = reg_write;
                        dest_d        = write_register;
                        cnt_clear     = 1'b1;
                    end else begin
                        wb_valid_d = 1'b1;
                        wb_we_d    = reg_write && (write_register != ZERO_IDX);
                        wb_reg_d   = write_register;
                        wb_data_d  = alu_result;
                    end
                end
            end
            ST_REQ: begin
                // Ack beats the timeout when both land in the same cycle
                if (mem_ack) begin
                    state_d    = ST_IDLE;
                    wb_valid_d = 1'b1;
                    wb_we_d    = reg_write_q && (dest_q != ZERO_IDX);
                    wb_reg_d   = dest_q;
                    wb_data_d  = load_to_reg_q ? mem_rdata : addr_q;
                end else if (cnt_expired) begin
                    state_d       = ST_IDLE;
                    wb_valid_d    = 1'b1;
                    wb_reg_d      = dest_q;
                    wb_data_d     = addr_q;
                    err_timeout_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, capture and writeback registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            we_q          <= 1'b0;
            load_to_reg_q <= 1'b0;
            reg_write_q   <= 1'b0;
            dest_q        <= '0;
            wb_valid_q    <= 1'b0;
            wb_we_q       <= 1'b0;
            wb_reg_q      <= '0;
            wb_data_q     <= '0;
            err_timeout_q <= 1'b0;
            err_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            we_q          <= we_d;
            load_to_reg_q <= load_to_reg_d;
            reg_write_q   <= reg_write_d;
            dest_q        <= dest_d;
            wb_valid_q    <= wb_valid_d;
            wb_we_q       <= wb_we_d;
            wb_reg_q      <= wb_reg_d;
            wb_data_q     <= wb_data_d;
            err_timeout_q <= err_timeout_d;
            err_illegal_q <= err_illegal_d;
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign mem_req     = (state_q == ST_REQ);
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign wb_valid    = wb_valid_q;
    assign wb_we       = wb_we_q;
    assign wb_register = wb_reg_q;
    assign wb_data     = wb_data_q;
    assign err_timeout = err_timeout_q;
    assign err_illegal = err_illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_access_stage
// Brief   : Self-checking bench for mem_access_stage with a transaction model
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

    localparam int TMO = 15;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        reg_write;
    logic [4:0]  write_register;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_register;
    logic [31:0] wb_data;
    logic        err_timeout;
    logic        err_illegal;

    int n_cmp;
    int n_fail;
    logic exp_err_to;
    logic exp_err_ill;

    mem_access_stage #(
        .DATA_WIDTH     (32),
        .REG_ADDR_WIDTH (5),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .alu_result     (alu_result),
        .store_data     (store_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_to_reg     (mem_to_reg),
        .reg_write      (reg_write),
        .write_register (write_register),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .wb_valid       (wb_valid),
        .wb_we          (wb_we),
        .wb_register    (wb_register),
        .wb_data        (wb_data),
        .err_timeout    (err_timeout),
        .err_illegal    (err_illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Hard stop in case anything stalls
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    // One complete op: drive it, follow the cache handshake, check the writeback.
    // ack_cycle = request cycle (1-based) in which mem_ack is raised; <1 or >TMO = never.
    task automatic run_op(input logic rd, input logic wr, input logic m2r, input logic rw,
                          input logic [4:0] dest, input logic [31:0] alu,
                          input logic [31:0] sd, input logic [31:0] rdata,
                          input int ack_cycle);
        logic        illegal;
        logic        is_mem;
        logic        tmo;
        int          reqc;
        logic        exp_we;
        logic [31:0] exp_data;
        illegal  = rd && wr;
        is_mem   = (rd || wr) && !illegal;
        tmo      = is_mem && (ack_cycle < 1 || ack_cycle > TMO);
        reqc     = !is_mem ? 0 : (tmo ? TMO : ack_cycle);
        exp_we   = rw && (dest != 5'd31) && !illegal && !tmo;
        exp_data = (is_mem && rd && m2r && !tmo) ? rdata : alu;

        @(negedge clock);
        n_cmp++;
        if ({wb_valid, in_ready, mem_req} !== 3'b010) begin
            n_fail++;
            $display("FAIL pre_accept: {wb_valid,in_ready,mem_req}=%b required 010",
                     {wb_valid, in_ready, mem_req});
        end
        in_valid = 1'b1; mem_read = rd; mem_write = wr; mem_to_reg = m2r;
        reg_write = rw; write_register = dest; alu_result = alu; store_data = sd;
        @(negedge clock);
        // Scramble inputs after accept: the stage must hold its captured copy
        in_valid = 1'b0; alu_result = $urandom; store_data = $urandom;
        mem_read = 1'($urandom); mem_write = 1'($urandom); write_register = 5'($urandom);
        for (int k = 1; k <= reqc; k++) begin
            n_cmp++;
            if ({mem_req, mem_we, mem_addr, mem_wdata, in_ready, wb_valid} !==
                {1'b1, wr, alu, sd, 1'b0, 1'b0}) begin
                n_fail++;
                $display("FAIL req_cycle%0d: req=%b we=%b addr=%h wdata=%h rdy=%b wbv=%b required req=1 we=%b addr=%h wdata=%h rdy=0 wbv=0",
                         k, mem_req, mem_we, mem_addr, mem_wdata, in_ready, wb_valid, wr, alu, sd);
            end
            if (k == ack_cycle) begin
                mem_ack = 1'b1; mem_rdata = rdata;
            end else begin
                mem_rdata = $urandom;
            end
            @(negedge clock);
            mem_ack = 1'b0;
        end
        if (illegal) exp_err_ill = 1'b1;
        if (tmo)     exp_err_to  = 1'b1;
        n_cmp++;
        if ({wb_valid, wb_we, wb_register, wb_data} !== {1'b1, exp_we, dest, exp_data}) begin
            n_fail++;
            $display("FAIL writeback: valid=%b we=%b reg=%0d data=%h required valid=1 we=%b reg=%0d data=%h",
                     wb_valid, wb_we, wb_register, wb_data, exp_we, dest, exp_data);
        end
        n_cmp++;
        if ({mem_req, in_ready, err_timeout, err_illegal} !== {1'b0, 1'b1, exp_err_to, exp_err_ill}) begin
            n_fail++;
            $display("FAIL post_status: req=%b rdy=%b err_to=%b err_ill=%b required req=0 rdy=1 err_to=%b err_ill=%b",
                     mem_req, in_ready, err_timeout, err_illegal, exp_err_to, exp_err_ill);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #1;
        exp_err_to = 1'b0; exp_err_ill = 1'b0;
        n_cmp++;
        if ({wb_valid, wb_we, wb_register, wb_data, mem_req, mem_we, mem_addr, mem_wdata,
             err_timeout, err_illegal, in_ready} !== {104'd0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state: wbv=%b wbwe=%b reg=%0d data=%h req=%b we=%b addr=%h wdata=%h eto=%b eill=%b rdy=%b required all 0 with rdy=1",
                     wb_valid, wb_we, wb_register, wb_data, mem_req, mem_we, mem_addr, mem_wdata,
                     err_timeout, err_illegal, in_ready);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_passthrough();
        run_op(1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 32'd30, 32'd0, 32'd0, 0);
        for (int i = 0; i < 6; i++) begin
            run_op(1'b0, 1'b0, 1'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom, $urandom, 0);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] q_data[$];
        logic [4:0]  q_reg[$];
        logic        q_we[$];
        logic [31:0] d;
        logic [4:0]  r;
        logic        w;
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            if (i > 0) begin
                d = q_data.pop_front(); r = q_reg.pop_front(); w = q_we.pop_front();
                n_cmp++;
                if ({wb_valid, wb_we, wb_register, wb_data, in_ready} !== {1'b1, w, r, d, 1'b1}) begin
                    n_fail++;
                    $display("FAIL b2b_%0d: valid=%b we=%b reg=%0d data=%h rdy=%b required valid=1 we=%b reg=%0d data=%h rdy=1",
                             i, wb_valid, wb_we, wb_register, wb_data, in_ready, w, r, d);
                end
            end
            in_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
            mem_to_reg = 1'($urandom); reg_write = 1'($urandom);
            write_register = (i == 5) ? 5'd31 : 5'($urandom);
            alu_result = $urandom;
            q_data.push_back(alu_result);
            q_reg.push_back(write_register);
            q_we.push_back(reg_write && write_register != 5'd31);
        end
        @(negedge clock);
        in_valid = 1'b0;
        d = q_data.pop_front(); r = q_reg.pop_front(); w = q_we.pop_front();
        n_cmp++;
        if ({wb_valid, wb_we, wb_register, wb_data} !== {1'b1, w, r, d}) begin
            n_fail++;
            $display("FAIL b2b_last: valid=%b we=%b reg=%0d data=%h required valid=1 we=%b reg=%0d data=%h",
                     wb_valid, wb_we, wb_register, wb_data, w, r, d);
        end
    endtask

    task automatic test_load();
        run_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h40, 32'h1234, 32'hDEADBEEF, 3);
        // Load without mem_to_reg writes back the address
        run_op(1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 32'h80, 32'h0, 32'hCAFEF00D, 2);
    endtask

    task automatic test_store();
        run_op(1'b0, 1'b1, 1'b0, 1'b0, 5'd5, 32'h10, 32'h55, 32'hFFFF0000, 1);
    endtask

    task automatic test_timeout();
        run_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 32'h100, 32'h0, 32'h11111111, 0);
        // Late ack while idle must be ignored
        mem_ack = 1'b1; mem_rdata = 32'h77777777;
        @(negedge clock);
        mem_ack = 1'b0;
        n_cmp++;
        if ({mem_req, wb_valid, in_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL late_ack: {req,wbv,rdy}=%b required 001", {mem_req, wb_valid, in_ready});
        end
        // Ack exactly on the limit cycle completes normally
        run_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd6, 32'h104, 32'h0, 32'h22222222, TMO);
    endtask

    task automatic test_edges();
        run_op(1'b0, 1'b0, 1'b0, 1'b1, 5'd31, 32'hABCD, 32'h0, 32'h0, 0);
        run_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd31, 32'h200, 32'h0, 32'h33333333, 2);
        run_op(1'b1, 1'b1, 1'b1, 1'b1, 5'd8, 32'h300, 32'h44, 32'h0, 1);
    endtask

    task automatic test_random_mem();
        for (int i = 0; i < 30; i++) begin
            run_op(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                   (i % 7 == 0) ? 5'd31 : 5'($urandom), $urandom, $urandom, $urandom,
                   int'($urandom_range(1, 18)));
        end
    endtask

    task automatic test_reset_mid_req();
        run_op(1'b1, 1'b1, 1'b0, 1'b0, 5'd2, 32'h0, 32'h0, 32'h0, 0);
        @(negedge clock);
        in_valid = 1'b1; mem_read = 1'b1; mem_write = 1'b0; mem_to_reg = 1'b1;
        reg_write = 1'b1; write_register = 5'd12; alu_result = 32'h500;
        @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        n_cmp++;
        if (mem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_req_active: mem_req=%b required 1", mem_req);
        end
        reset_n = 1'b0;
        #1;
        exp_err_to = 1'b0; exp_err_ill = 1'b0;
        n_cmp++;
        if ({mem_req, wb_valid, err_timeout, err_illegal, in_ready} !== 5'b00001) begin
            n_fail++;
            $display("FAIL mid_req_reset: {req,wbv,eto,eill,rdy}=%b required 00001",
                     {mem_req, wb_valid, err_timeout, err_illegal, in_ready});
        end
        @(negedge clock);
        reset_n = 1'b1;
        mem_ack = 1'b1;
        @(negedge clock);
        mem_ack = 1'b0;
        n_cmp++;
        if ({mem_req, wb_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL post_reset_quiet: {req,wbv}=%b required 00", {mem_req, wb_valid});
        end
        run_op(1'b1, 1'b0, 1'b1, 1'b1, 5'd13, 32'h600, 32'h0, 32'h5A5A5A5A, 2);
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        exp_err_to = 1'b0; exp_err_ill = 1'b0;
        in_valid = 1'b0; alu_result = '0; store_data = '0; mem_read = 1'b0;
        mem_write = 1'b0; mem_to_reg = 1'b0; reg_write = 1'b0; write_register = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        test_reset();
        test_passthrough();
        test_back_to_back();
        test_load();
        test_store();
        test_timeout();
        test_edges();
        test_random_mem();
        test_reset_mid_req();
        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
